// File: rtl/hamming_secded_decoder.sv
// hamming_secded_decoder
//   Receive side of a 16-bit Hamming SECDED link. It accepts a codeword as
//   two bytes, lower byte first, and computes the syndrome and overall
//   parity. It then returns the 11 data bits, corrected when a single-bit
//   error is present, together with a status code.
//
//   Codeword w[15:0] = {upper, lower}:
//     w[0] overall even parity, w[1]/w[2]/w[4]/w[8] = p1/p2/p4/p8,
//     data d0=w3, d1=w5, d2=w6, d3=w7, d10..d4 = w15..w9.
//
//   Ports
//     clk          rising-edge clock
//     reset        asynchronous, active-high; clears all state
//     in_byte      codeword byte (lower first, then upper)
//     in_valid     in_byte valid
//     in_ready     decoder can accept a byte (decoded from state)
//     out_data     decoded data d[10:0]
//     out_status   00 clean, 01 single corrected, 10 double detected
//     out_valid    out_data/out_status valid
//     out_ready    consumer accepts result
//     clr_cnt      synchronous clear of both error counters
//     corr_cnt     saturating single-error count
//     dbl_cnt      saturating double-error count
//
//   Build option: define HAMM_DEC_STATS_EN to implement the saturating
//   counters. Without it the counters read 0 and clr_cnt is ignored.

module hamming_secded_decoder #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       in_byte,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [10:0]      out_data,
  output logic [1:0]       out_status,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] corr_cnt,
  output logic [CNT_W-1:0] dbl_cnt
);

  localparam logic [1:0] S_LO  = 2'd0;
  localparam logic [1:0] S_HI  = 2'd1;
  localparam logic [1:0] S_DEC = 2'd2;
  localparam logic [1:0] S_OUT = 2'd3;

  localparam logic [1:0] ST_CLEAN  = 2'b00;
  localparam logic [1:0] ST_SINGLE = 2'b01;
  localparam logic [1:0] ST_DOUBLE = 2'b10;

  // Syndrome: XOR of the positions of all set bits among w[15:1].
  function automatic logic [3:0] syndrome(input logic [15:0] w);
    logic [3:0] s;
    s = 4'd0;
    for (int i = 1; i < 16; i++) begin
      if (w[i]) begin
        s = s ^ i[3:0];
      end else begin
        s = s;
      end
    end
    return s;
  endfunction

  function automatic logic [10:0] extract(input logic [15:0] w);
    return {w[15:9], w[7:5], w[3]};
  endfunction

  logic [1:0]  state_q, state_d;
  logic [7:0]  lo_q, lo_d;
  logic [7:0]  hi_q, hi_d;
  logic [10:0] data_q, data_d;
  logic [1:0]  status_q, status_d;

  logic [15:0] word_s;
  logic [3:0]  syn_s;
  logic        par_s;
  logic [15:0] fixed_s;
  logic [10:0] dec_data_s;
  logic [1:0]  dec_status_s;

  // Syndrome decode and correction of the captured codeword.
  always_comb begin
    word_s  = {hi_q, lo_q};
    syn_s   = syndrome(word_s);
    par_s   = ^word_s;
    // Syndrome 0 with odd parity points at w[0] itself.
    fixed_s = word_s ^ (16'd1 << syn_s);
    if (par_s) begin
      dec_data_s   = extract(fixed_s);
      dec_status_s = ST_SINGLE;
    end else if (syn_s != 4'd0) begin
      dec_data_s   = extract(word_s);
      dec_status_s = ST_DOUBLE;
    end else begin
      dec_data_s   = extract(word_s);
      dec_status_s = ST_CLEAN;
    end
  end

  // Next-state and capture logic for the byte-assembly / output FSM.
  always_comb begin
    state_d  = state_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    data_d   = data_q;
    status_d = status_q;
    case (state_q)
      S_LO: begin
        if (in_valid) begin
          lo_d    = in_byte;
          state_d = S_HI;
        end else begin
          state_d = S_LO;
        end
      end
      S_HI: begin
        if (in_valid) begin
          hi_d    = in_byte;
          state_d = S_DEC;
        end else begin
          state_d = S_HI;
        end
      end
      S_DEC: begin
        data_d   = dec_data_s;
        status_d = dec_status_s;
        state_d  = S_OUT;
      end
      S_OUT: begin
        if (out_ready) begin
          state_d = S_LO;
        end else begin
          state_d = S_OUT;
        end
      end
      default: begin
        state_d = S_LO;
      end
    endcase
  end

  // State, captured bytes and registered result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_LO;
      lo_q     <= 8'd0;
      hi_q     <= 8'd0;
      data_q   <= 11'd0;
      status_q <= 2'b00;
    end else begin
      state_q  <= state_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      data_q   <= data_d;
      status_q <= status_d;
    end
  end

  assign in_ready   = (state_q == S_LO) || (state_q == S_HI);
  assign out_valid  = (state_q == S_OUT);
  assign out_data   = data_q;
  assign out_status = status_q;

`ifdef HAMM_DEC_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] corr_q, corr_d;
  logic [CNT_W-1:0] dbl_q, dbl_d;
  logic             entry_s;

  // Counters step on the S_DEC -> S_OUT edge; clear wins over increment.
  always_comb begin
    entry_s = (state_q == S_DEC);
    corr_d  = corr_q;
    dbl_d   = dbl_q;
    if (clr_cnt) begin
      corr_d = {CNT_W{1'b0}};
      dbl_d  = {CNT_W{1'b0}};
    end else if (entry_s && (dec_status_s == ST_SINGLE) && (corr_q != CNT_MAX)) begin
      corr_d = corr_q + CNT_ONE;
    end else if (entry_s && (dec_status_s == ST_DOUBLE) && (dbl_q != CNT_MAX)) begin
      dbl_d = dbl_q + CNT_ONE;
    end else begin
      corr_d = corr_q;
      dbl_d  = dbl_q;
    end
  end

  // Error counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      corr_q <= {CNT_W{1'b0}};
      dbl_q  <= {CNT_W{1'b0}};
    end else begin
      corr_q <= corr_d;
      dbl_q  <= dbl_d;
    end
  end

  assign corr_cnt = corr_q;
  assign dbl_cnt  = dbl_q;
`else
  logic unused_clr_s;
  assign unused_clr_s = clr_cnt;
  assign corr_cnt     = {CNT_W{1'b0}};
  assign dbl_cnt      = {CNT_W{1'b0}};
`endif

endmodule
